// File: rtl/zeroskip_pkg.sv
// Shared types and helpers for the zero-skip decompressor.
// Holds the control FSM state encoding plus popcount/beat-count arithmetic.
package zeroskip_pkg;

    typedef enum logic [1:0] {
        StIdle,
        StLoad,
        StEmit
    } state_e;

    // Widest header mask the popcount helper accepts; callers zero-extend.
    localparam int unsigned MaxMaskW = 64;

    function automatic int unsigned popcount(input logic [MaxMaskW-1:0] v);
        int unsigned n;
        n = 0;
        for (int i = 0; i < MaxMaskW; i++) begin
            if (v[i]) n++;
        end
        return n;
    endfunction

    function automatic int unsigned beats_for(input int unsigned cnt, input int unsigned lanes);
        return (cnt + lanes - 1) / lanes;
    endfunction

endpackage

// File: rtl/zeroskip_decoder_if.sv
// Header, payload and dense-output channels of the zero-skip decompressor.
// slave is the decoder side; master is the producer/consumer side.
interface zeroskip_decoder_if #(
    parameter int unsigned GROUP_SIZE = 32,
    parameter int unsigned DATA_W     = 8,
    parameter int unsigned BEAT_LANES = 4
) ();

    logic                         hdr_valid;
    logic                         hdr_ready;
    logic [GROUP_SIZE-1:0]        hdr_znz;

    logic                         pay_valid;
    logic                         pay_ready;
    logic [BEAT_LANES*DATA_W-1:0] pay_data;

    logic                         out_valid;
    logic                         out_ready;
    logic [GROUP_SIZE*DATA_W-1:0] out_act;
    logic [GROUP_SIZE-1:0]        out_znz;

    logic                         err_overflow;

    modport slave (
        input  hdr_valid, hdr_znz, pay_valid, pay_data, out_ready,
        output hdr_ready, pay_ready, out_valid, out_act, out_znz, err_overflow
    );

    modport master (
        output hdr_valid, hdr_znz, pay_valid, pay_data, out_ready,
        input  hdr_ready, pay_ready, out_valid, out_act, out_znz, err_overflow
    );

endinterface

// File: rtl/zeroskip_scatter.sv
// Combinational scatter: places packed nonzeros onto their dense lanes.
// Lane i with its mask bit set takes packed slot rank(i) = set bits below i.
module zeroskip_scatter #(
    parameter int unsigned GROUP_SIZE   = 32,
    parameter int unsigned GROUP_NZ_MAX = 16,
    parameter int unsigned DATA_W       = 8
) (
    input  logic [GROUP_SIZE-1:0]          mask,
    input  logic [GROUP_NZ_MAX*DATA_W-1:0] packed_buf,
    output logic [GROUP_SIZE*DATA_W-1:0]   dense
);

    always_comb begin
        int unsigned rank;
        rank  = 0;
        dense = '0;
        for (int unsigned i = 0; i < GROUP_SIZE; i++) begin
            if (mask[i]) begin
                // Guard keeps the read in range even for an unclamped mask.
                if (rank < GROUP_NZ_MAX) begin
                    dense[i*DATA_W +: DATA_W] = packed_buf[rank*DATA_W +: DATA_W];
                end
                rank++;
            end
        end
    end

endmodule

// File: rtl/zeroskip_decoder.sv
// Streaming zero-skip decompressor: header mask, then packed payload beats,
// producing one registered dense activation vector per group.
module zeroskip_decoder
    import zeroskip_pkg::*;
#(
    parameter int unsigned GROUP_SIZE   = 32,
    parameter int unsigned GROUP_NZ_MAX = 16,
    parameter int unsigned DATA_W       = 8,
    parameter int unsigned BEAT_LANES   = 4
) (
    input  logic            clk,
    input  logic            rst_n,
    zeroskip_decoder_if.slave bus
);

    localparam int unsigned CNT_W = $clog2(GROUP_NZ_MAX) + 1;
    localparam int unsigned BUF_W = GROUP_NZ_MAX * DATA_W;
    localparam int unsigned ACT_W = GROUP_SIZE * DATA_W;

    state_e                state_q, state_d;
    logic [GROUP_SIZE-1:0] mask_q, mask_d;
    logic [CNT_W-1:0]      cnt_q, cnt_d;
    logic [CNT_W-1:0]      beats_q, beats_d;
    logic [CNT_W-1:0]      beat_idx_q, beat_idx_d;
    logic [BUF_W-1:0]      packed_q, packed_d;
    logic [ACT_W-1:0]      out_act_q, out_act_d;
    logic [GROUP_SIZE-1:0] out_znz_q, out_znz_d;
    logic                  err_q, err_d;

    logic [GROUP_SIZE-1:0] mask_clamped;
    logic [CNT_W-1:0]      hdr_cnt;
    logic [CNT_W-1:0]      hdr_beats;
    logic                  hdr_over;
    logic [ACT_W-1:0]      scatter_dense;

    // Keep only the lowest GROUP_NZ_MAX set bits of an oversized header.
    always_comb begin
        int unsigned kept;
        kept         = 0;
        mask_clamped = '0;
        for (int unsigned i = 0; i < GROUP_SIZE; i++) begin
            if (bus.hdr_znz[i] && kept < GROUP_NZ_MAX) begin
                mask_clamped[i] = 1'b1;
                kept++;
            end
        end
        hdr_cnt   = CNT_W'(kept);
        hdr_beats = CNT_W'(beats_for(32'(hdr_cnt), BEAT_LANES));
        hdr_over  = popcount(MaxMaskW'(bus.hdr_znz)) > GROUP_NZ_MAX;
    end

    // Packed buffer write; slots at or beyond cnt in the final beat are dropped.
    always_comb begin
        int unsigned slot;
        slot     = 0;
        packed_d = packed_q;
        if (state_q == StLoad && bus.pay_valid) begin
            for (int unsigned l = 0; l < BEAT_LANES; l++) begin
                slot = 32'(beat_idx_q) * BEAT_LANES + l;
                if (slot < 32'(cnt_q)) begin
                    packed_d[slot*DATA_W +: DATA_W] = bus.pay_data[l*DATA_W +: DATA_W];
                end
            end
        end
    end

    // Scatter sees the buffer including the beat being accepted this cycle.
    zeroskip_scatter #(
        .GROUP_SIZE  (GROUP_SIZE),
        .GROUP_NZ_MAX(GROUP_NZ_MAX),
        .DATA_W      (DATA_W)
    ) u_scatter (
        .mask      (mask_q),
        .packed_buf(packed_d),
        .dense     (scatter_dense)
    );

    always_comb begin
        state_d    = state_q;
        mask_d     = mask_q;
        cnt_d      = cnt_q;
        beats_d    = beats_q;
        beat_idx_d = beat_idx_q;
        out_act_d  = out_act_q;
        out_znz_d  = out_znz_q;
        err_d      = 1'b0;

        unique case (state_q)
            StIdle: begin
                if (bus.hdr_valid) begin
                    mask_d     = mask_clamped;
                    cnt_d      = hdr_cnt;
                    beats_d    = hdr_beats;
                    beat_idx_d = '0;
                    err_d      = hdr_over;
                    if (hdr_cnt == '0) begin
                        out_act_d = '0;
                        out_znz_d = '0;
                        state_d   = StEmit;
                    end else begin
                        state_d = StLoad;
                    end
                end
            end
            StLoad: begin
                if (bus.pay_valid) begin
                    beat_idx_d = beat_idx_q + CNT_W'(1);
                    if (beat_idx_q == beats_q - CNT_W'(1)) begin
                        out_act_d = scatter_dense;
                        out_znz_d = mask_q;
                        state_d   = StEmit;
                    end
                end
            end
            StEmit: begin
                if (bus.out_ready) state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= StIdle;
            mask_q     <= '0;
            cnt_q      <= '0;
            beats_q    <= '0;
            beat_idx_q <= '0;
            packed_q   <= '0;
            out_act_q  <= '0;
            out_znz_q  <= '0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            mask_q     <= mask_d;
            cnt_q      <= cnt_d;
            beats_q    <= beats_d;
            beat_idx_q <= beat_idx_d;
            packed_q   <= packed_d;
            out_act_q  <= out_act_d;
            out_znz_q  <= out_znz_d;
            err_q      <= err_d;
        end
    end

    assign bus.hdr_ready    = (state_q == StIdle);
    assign bus.pay_ready    = (state_q == StLoad);
    assign bus.out_valid    = (state_q == StEmit);
    assign bus.out_act      = out_act_q;
    assign bus.out_znz      = out_znz_q;
    assign bus.err_overflow = err_q;

endmodule

// File: tb/tb_zeroskip_decoder.sv
// Directed bench for zeroskip_decoder with hand-computed expected vectors.
module tb_zeroskip_decoder;

    localparam int unsigned GS = 32;
    localparam int unsigned NZ = 16;
    localparam int unsigned DW = 8;
    localparam int unsigned BL = 4;

    // Bytes 1..16, lowest byte first.
    localparam logic [127:0] SEQ = 128'h100F0E0D0C0B0A090807060504030201;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   total = 0;
    int   bad = 0;

    always #5 clk = ~clk;

    zeroskip_decoder_if #(.GROUP_SIZE(GS), .DATA_W(DW), .BEAT_LANES(BL)) bus ();

    zeroskip_decoder #(
        .GROUP_SIZE  (GS),
        .GROUP_NZ_MAX(NZ),
        .DATA_W      (DW),
        .BEAT_LANES  (BL)
    ) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus)
    );

    task automatic chk(input string tag, input logic [255:0] got, input logic [255:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic send_hdr(input logic [31:0] m);
        int n;
        n = 0;
        @(negedge clk);
        bus.hdr_valid = 1'b1;
        bus.hdr_znz   = m;
        while (!bus.hdr_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (n >= 50) chk("hdr_wait", 256'(bus.hdr_ready), 256'd1);
        @(posedge clk);
        #1 bus.hdr_valid = 1'b0;
    endtask

    task automatic send_beat(input logic [31:0] d, input int gap);
        int n;
        n = 0;
        repeat (gap) @(negedge clk);
        @(negedge clk);
        bus.pay_valid = 1'b1;
        bus.pay_data  = d;
        while (!bus.pay_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (n >= 50) chk("pay_wait", 256'(bus.pay_ready), 256'd1);
        @(posedge clk);
        #1 bus.pay_valid = 1'b0;
    endtask

    task automatic accept();
        @(negedge clk);
        bus.out_ready = 1'b1;
        @(posedge clk);
        #1 bus.out_ready = 1'b0;
    endtask

    function automatic logic [31:0] seq_beat(input int b);
        logic [31:0] d;
        for (int k = 0; k < 4; k++) d[k*8 +: 8] = 8'(4 * b + k + 1);
        return d;
    endfunction

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_hdr_ready"}, 256'(bus.hdr_ready), 256'd1);
        chk({tag, "_pay_ready"}, 256'(bus.pay_ready), 256'd0);
        chk({tag, "_out_valid"}, 256'(bus.out_valid), 256'd0);
        chk({tag, "_out_act"}, bus.out_act, 256'd0);
        chk({tag, "_out_znz"}, 256'(bus.out_znz), 256'd0);
        chk({tag, "_err"}, 256'(bus.err_overflow), 256'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [255:0] exp_act;
        bus.hdr_valid = 1'b0;
        bus.hdr_znz   = '0;
        bus.pay_valid = 1'b0;
        bus.pay_data  = '0;
        bus.out_ready = 1'b0;

        repeat (3) @(negedge clk);
        chk_reset_outputs("rst");
        rst_n = 1'b1;

        // Sparse mask, single beat; lanes 2/3 of the beat are past cnt.
        send_hdr(32'h0000_0005);
        chk("a_pay_ready", 256'(bus.pay_ready), 256'd1);
        send_beat(32'h2211_BBAA, 0);
        chk("a_valid", 256'(bus.out_valid), 256'd1);
        chk("a_act", bus.out_act, 256'h00BB_00AA);
        chk("a_znz", 256'(bus.out_znz), 256'h5);
        accept();
        chk("a_idle", 256'(bus.hdr_ready), 256'd1);

        // Empty group goes straight to EMIT with zeros.
        send_hdr(32'h0000_0000);
        chk("b_valid", 256'(bus.out_valid), 256'd1);
        chk("b_pay_ready", 256'(bus.pay_ready), 256'd0);
        chk("b_act", bus.out_act, 256'd0);
        chk("b_znz", 256'(bus.out_znz), 256'd0);
        accept();

        // Upper half dense, random gaps between beats.
        send_hdr(32'hFFFF_0000);
        for (int b = 0; b < 4; b++) begin
            send_beat(seq_beat(b), int'($urandom_range(0, 3)));
            if (b == 2) chk("c_not_early", 256'(bus.out_valid), 256'd0);
        end
        chk("c_valid", 256'(bus.out_valid), 256'd1);
        chk("c_act", bus.out_act, {SEQ, 128'd0});
        chk("c_znz", 256'(bus.out_znz), 256'hFFFF_0000);
        accept();

        // Overflow: clamped to the low 16 lanes, one-cycle error pulse.
        send_hdr(32'hFFFF_FFFF);
        chk("d_err_on", 256'(bus.err_overflow), 256'd1);
        @(posedge clk);
        #1 chk("d_err_off", 256'(bus.err_overflow), 256'd0);
        for (int b = 0; b < 4; b++) send_beat(seq_beat(b), 0);
        chk("d_valid", 256'(bus.out_valid), 256'd1);
        chk("d_znz", 256'(bus.out_znz), 256'h0000_FFFF);
        // Backpressure: output must hold and no header may be taken.
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            chk("d_hold_act", bus.out_act, {128'd0, SEQ});
            chk("d_hold_hdr_ready", 256'(bus.hdr_ready), 256'd0);
            chk("d_hold_valid", 256'(bus.out_valid), 256'd1);
        end
        accept();

        // Scattered lanes 0, 8, 31; beat lane 3 is past cnt.
        send_hdr(32'h8000_0101);
        send_beat(32'h4403_0201, 1);
        exp_act = (256'h03 << 248) | (256'h02 << 64) | 256'h01;
        chk("e_act", bus.out_act, exp_act);
        chk("e_znz", 256'(bus.out_znz), 256'h8000_0101);
        accept();

        // Reset in the middle of LOAD discards the partial group.
        send_hdr(32'h0000_FFFF);
        send_beat(32'h0D0C_0B0A, 0);
        send_beat(32'h1D1C_1B1A, 0);
        @(negedge clk);
        rst_n = 1'b0;
        #1 chk_reset_outputs("f_rst");
        @(negedge clk);
        rst_n = 1'b1;
        send_hdr(32'h0000_0001);
        send_beat(32'h5555_557F, 0);
        chk("f_valid", 256'(bus.out_valid), 256'd1);
        chk("f_act", bus.out_act, 256'h7F);
        chk("f_znz", 256'(bus.out_znz), 256'h1);
        accept();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/zeroskip_decoder.md
# zeroskip_decoder

Streaming zero-skip decompressor: takes a group's nonzero mask (header) followed by its packed nonzero activations (payload, BEAT_LANES values per beat) and rebuilds the dense GROUP_SIZE-wide activation vector, with zeros at masked positions. It is the inverse of the zero-skip packer and sits on the read side of compressed activation storage, feeding dense compute lanes.

## Interface

Parameters:
- GROUP_SIZE, 32, dense group width (lanes)
- GROUP_NZ_MAX, 16, max packed nonzeros per group (shared by 8:32 and 16:32 modes)
- DATA_W, 8, activation width
- BEAT_LANES, 4, packed values per payload beat; must divide GROUP_NZ_MAX

Ports:
- clk  in  1  clock; all state on rising edge
- rst_n  in  1  asynchronous active-low reset
- hdr_valid  in  1  header valid
- hdr_ready  out  1  header ready; high only in IDLE
- hdr_znz  in  GROUP_SIZE  nonzero mask; bit i set means dense lane i is nonzero
- pay_valid  in  1  payload beat valid
- pay_ready  out  1  payload ready; high only in LOAD
- pay_data  in  BEAT_LANES×DATA_W  packed values, lane 0 first
- out_valid  out  1  dense group valid
- out_ready  in  1  downstream accept
- out_act  out  GROUP_SIZE×DATA_W  dense activations
- out_znz  out  GROUP_SIZE  mask actually honoured
- err_overflow  out  1  one-cycle pulse when the header popcount exceeds GROUP_NZ_MAX

## Operation

- States: IDLE, LOAD, EMIT.
- IDLE: hdr_ready=1. On hdr_valid, latch the mask and compute cnt = popcount(mask).
  - If cnt > GROUP_NZ_MAX: pulse err_overflow and clamp the mask, keeping only the lowest GROUP_NZ_MAX set bits. cnt becomes GROUP_NZ_MAX.
  - cnt==0 → EMIT. Otherwise → LOAD with beats_needed = ceil(cnt/BEAT_LANES) and beat_idx=0.
- LOAD: pay_ready=1. Each pay_valid&&pay_ready beat writes pay_data into the packed buffer at slots beat_idx*BEAT_LANES + lane, then increments beat_idx.
  - Lanes with index ≥ cnt in the final beat are ignored.
  - No beat arriving means no progress; there is no timeout.
  - On the last beat: compute the scatter, register it into out_act/out_znz, then → EMIT.
- Scatter: for every dense lane i with mask bit set, out_act[i] = packed[rank(i)], where rank(i) = number of set bits below i. Unset lanes are 0.
- EMIT: out_valid=1. out_act and out_znz hold stable until out_ready; then → IDLE. For cnt==0, out_act is all zero.
- Packed buffer width is fixed at GROUP_NZ_MAX; buffer index arithmetic uses $clog2(GROUP_NZ_MAX)+1 bits so cnt==GROUP_NZ_MAX is representable.

## Timing

- Reset values: state=IDLE, hdr_ready=1, pay_ready=0, out_valid=0, out_act=0, out_znz=0, err_overflow=0, beat_idx=0.
- Header accepted in cycle N:
  - first beat can be accepted in N+1;
  - err_overflow is high in N+1 only.
- Last beat accepted in cycle M → out_valid high in M+1.
- cnt==0 → out_valid high in N+1.
- Minimum group period = beats_needed + 2 cycles (header is not accepted during EMIT).
- Reset asserted mid-LOAD or mid-EMIT aborts the group immediately; partial payload is discarded and outputs return to reset values.
- hdr_valid seen outside IDLE is ignored. pay_valid seen outside LOAD is ignored.

## Structure

- zeroskip_pkg holds:
  - the state enum typedef (IDLE/LOAD/EMIT);
  - a function beats_for(cnt, BEAT_LANES);
  - a popcount function.
- Sub-module zeroskip_scatter: purely combinational mask + packed buffer → dense vector via prefix rank. Parameterised on GROUP_SIZE, GROUP_NZ_MAX, DATA_W. Instantiated once; the output is registered in the parent.

## Test plan

Defaults: GROUP_SIZE=32, GROUP_NZ_MAX=16, BEAT_LANES=4.

- Mask 0x00000005, one beat {0xAA,0xBB,0x11,0x22} → out_act[0]=0xAA, out_act[2]=0xBB, all others 0; out_valid the cycle after the beat.
- Mask 0x00000000 → pay_ready never asserts; out_valid at N+1 with all-zero out_act.
- Mask 0xFFFF0000, 4 beats carrying values 1..16 → out_act[16+k]=k+1, out_act[0..15]=0, out_znz=0xFFFF0000.
- Mask 0xFFFFFFFF → err_overflow for exactly one cycle; 4 beats consumed; out_znz=0x0000FFFF; lanes 16..31 are 0.
- Backpressure: out_ready low for 5 cycles → out_act stable and hdr_ready=0 throughout. Random pay_valid gaps in LOAD → correct final vector.
- rst_n low after 2 of 4 beats → all outputs at reset values. The next header 0x00000001 with beat {0x7F,…} yields out_act[0]=0x7F.
